// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-granular round-robin arbiter sharing one FIFO write port among NREQ producers.
// Optional macro FIFO_WR_ARB_STATS_EN adds per-requester completed-packet counters on grant_cnt.
module fifo_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   fifo_write,
  output logic [DWIDTH-1:0]      fifo_din,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [NREQ*16-1:0]     grant_cnt,
`endif
  input  logic                   fifo_full
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t            state, state_d;
  logic [NREQ-1:0]   grant_d;
  logic [PW-1:0]     owner, owner_d;
  logic [PW-1:0]     rr_ptr, rr_ptr_d;
  logic [PW-1:0]     sel_idx, cand;
  logic              sel_found;
  logic              owner_valid, owner_last, accept;
  logic [DWIDTH-1:0] owner_data;

  // Handshake: a beat of requester i moves into the FIFO in exactly the cycles where
  // req_valid[i] & req_ready[i]; req_ready is combinational (valid & ~full for the owner),
  // so a producer must hold valid/data/last stable until it sees ready.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NREQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_valid = |(req_valid & grant);
    owner_last  = |(req_last & grant);
    owner_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) owner_data = req_data[i*DWIDTH +: DWIDTH];
    end
  end

  assign accept     = (state == LOCK) && owner_valid && !fifo_full;
  assign fifo_write = accept;
  assign fifo_din   = accept ? owner_data : '0;
  assign req_ready  = accept ? grant : '0;
  // busy is the observable FSM state (IDLE=0, LOCK=1).
  assign busy       = (state == LOCK);

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    owner_d  = owner;
    rr_ptr_d = rr_ptr;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_d = LOCK;
          owner_d = sel_idx;
          for (int i = 0; i < NREQ; i++) grant_d[i] = (sel_idx == PW'(i));
        end
      end
      LOCK: begin
        // Only an accepted beat can end the packet; req_last on a stalled beat is ignored.
        if (accept && owner_last) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = owner;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= '0;
      rr_ptr <= PW'(NREQ - 1);
    end else begin
      state  <= state_d;
      grant  <= grant_d;
      owner  <= owner_d;
      rr_ptr <= rr_ptr_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept && owner_last && grant[i])
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector table plus multi-cycle sequences against a 16-deep FIFO model.
module tb_fifo_wr_arbiter;
  localparam int NREQ   = 4;
  localparam int DWIDTH = 32;
  localparam int DEPTH  = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*DWIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]        req_last = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic                   fifo_write;
  logic [DWIDTH-1:0]      fifo_din;
  logic                   fifo_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ*16-1:0]     grant_cnt;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .busy(busy),
    .fifo_write(fifo_write), .fifo_din(fifo_din),
`ifdef FIFO_WR_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .fifo_full(fifo_full)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int rdy_full_cnt = 0;
  bit model_full = 1'b0;
  logic [DWIDTH-1:0] fifo_q[$];
  logic [DWIDTH-1:0] exp_q[$];

  logic [NREQ-1:0]   s_grant, s_ready;
  logic              s_busy, s_write;
  logic [DWIDTH-1:0] s_din;

  // producer models
  int npkt[NREQ], nbeats[NREQ], pkt[NREQ], beat[NREQ];
  bit hold[NREQ];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_one(input string name);
    logic [DWIDTH-1:0] got, want;
    if (fifo_q.size() == 0 || exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: fifo holds %0d entries, expected queue holds %0d", name, fifo_q.size(), exp_q.size());
    end else begin
      got  = fifo_q.pop_front();
      want = exp_q.pop_front();
      chk(name, 64'(got), 64'(want));
    end
  endtask

  task automatic drain(input string name);
    while (fifo_q.size() > 0) pop_one(name);
    chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Called just after a falling edge with inputs set; samples outputs, commits the edge.
  task automatic tick(input bit pop);
    #1;
    s_grant = grant; s_busy = busy; s_write = fifo_write; s_ready = req_ready; s_din = fifo_din;
    if (fifo_full && s_ready != '0) rdy_full_cnt++;
    if (s_write === 1'b1) begin
      chk("no_write_when_full", {63'd0, fifo_full}, 64'd0);
      fifo_q.push_back(s_din);
      n_writes++;
    end
    @(posedge clk);
    #1;
    if (pop) pop_one("pop_order");
    if (model_full) fifo_full = (fifo_q.size() >= DEPTH);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_prod();
    for (int i = 0; i < NREQ; i++) begin
      npkt[i] = 0; nbeats[i] = 1; pkt[i] = 0; beat[i] = 0; hold[i] = 1'b0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (pkt[i] < npkt[i]) && !hold[i];
      req_last[i]  = (beat[i] == nbeats[i] - 1);
      req_data[i*DWIDTH +: DWIDTH] = DWIDTH'((i << 8) | (pkt[i] << 4) | beat[i]);
    end
  endtask

  task automatic step(input bit pop);
    drive();
    tick(pop);
    for (int i = 0; i < NREQ; i++) begin
      if (s_ready[i]) begin
        beat[i]++;
        if (beat[i] == nbeats[i]) begin
          beat[i] = 0;
          pkt[i]++;
        end
      end
    end
  endtask

  function automatic bit all_done();
    bit d = 1'b1;
    for (int i = 0; i < NREQ; i++) if (pkt[i] < npkt[i]) d = 1'b0;
    return d;
  endfunction

  task automatic run_to_idle(input int max_cyc, input string name);
    bit done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      step(1'b0);
      if (all_done() && !s_busy) done = 1'b1;
    end
    chk({name, "_done"}, {63'd0, done}, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_prod();
    drive();
    tick(1'b0);
    rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    n_writes = 0;
    rdy_full_cnt = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [7:0]  tag;
    logic [3:0]  e_grant;
    logic        e_busy;
    logic        e_write;
    logic [3:0]  e_ready;
    logic [31:0] e_din;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic f, logic [7:0] t,
                              logic [3:0] g, logic b, logic w, logic [3:0] r, logic [31:0] d);
    vec_t x;
    x.valid = v; x.last = l; x.full = f; x.tag = t;
    x.e_grant = g; x.e_busy = b; x.e_write = w; x.e_ready = r; x.e_din = d;
    return x;
  endfunction

  initial begin
    // Row data for requester i is (i<<8)|tag. Starts from reset: rr_ptr=3.
    vecs[0]  = mk(4'b0001, 4'b0000, 0, 8'h00, 4'b0000, 0, 0, 4'b0000, 32'h000);
    vecs[1]  = mk(4'b0001, 4'b0000, 0, 8'h00, 4'b0001, 1, 1, 4'b0001, 32'h000);
    vecs[2]  = mk(4'b0001, 4'b0000, 0, 8'h01, 4'b0001, 1, 1, 4'b0001, 32'h001);
    vecs[3]  = mk(4'b0001, 4'b0001, 0, 8'h02, 4'b0001, 1, 1, 4'b0001, 32'h002);
    vecs[4]  = mk(4'b0000, 4'b0000, 0, 8'h03, 4'b0000, 0, 0, 4'b0000, 32'h000);
    vecs[5]  = mk(4'b0011, 4'b0000, 0, 8'h05, 4'b0000, 0, 0, 4'b0000, 32'h000);
    vecs[6]  = mk(4'b0011, 4'b0010, 1, 8'h06, 4'b0010, 1, 0, 4'b0000, 32'h000);
    vecs[7]  = mk(4'b0001, 4'b0000, 0, 8'h06, 4'b0010, 1, 0, 4'b0000, 32'h000);
    vecs[8]  = mk(4'b0011, 4'b0010, 0, 8'h07, 4'b0010, 1, 1, 4'b0010, 32'h107);
    vecs[9]  = mk(4'b0011, 4'b0000, 0, 8'h08, 4'b0000, 0, 0, 4'b0000, 32'h000);
    vecs[10] = mk(4'b0011, 4'b0001, 0, 8'h09, 4'b0001, 1, 1, 4'b0001, 32'h009);
    vecs[11] = mk(4'b1000, 4'b0000, 0, 8'h0A, 4'b0000, 0, 0, 4'b0000, 32'h000);
    vecs[12] = mk(4'b1000, 4'b1000, 0, 8'h0C, 4'b1000, 1, 1, 4'b1000, 32'h30C);
    vecs[13] = mk(4'b0001, 4'b0000, 0, 8'h0D, 4'b0000, 0, 0, 4'b0000, 32'h000);
    vecs[14] = mk(4'b0001, 4'b0001, 1, 8'h0E, 4'b0001, 1, 0, 4'b0000, 32'h000);
    vecs[15] = mk(4'b0001, 4'b0001, 0, 8'h0F, 4'b0001, 1, 1, 4'b0001, 32'h00F);
    vecs[16] = mk(4'b0000, 4'b0000, 0, 8'h10, 4'b0000, 0, 0, 4'b0000, 32'h000);

    @(negedge clk);
    do_reset();

    // reset state: all outputs low while idle
    tick(1'b0);
    chk("reset_outputs", 64'({s_grant, s_busy, s_write, s_ready, s_din}), 64'd0);

    // table: single packet, full stall, owner gap, rotation, single-beat packets
    for (int k = 0; k < NV; k++) begin
      req_valid = vecs[k].valid;
      req_last  = vecs[k].last;
      fifo_full = vecs[k].full;
      for (int i = 0; i < NREQ; i++)
        req_data[i*DWIDTH +: DWIDTH] = (32'(i) << 8) | 32'(vecs[k].tag);
      tick(1'b0);
      chk($sformatf("vec%0d", k), 64'({s_grant, s_busy, s_write, s_ready, s_din}),
          64'({vecs[k].e_grant, vecs[k].e_busy, vecs[k].e_write, vecs[k].e_ready, vecs[k].e_din}));
    end
    fifo_full = 1'b0;
    model_full = 1'b1;

    // all four requesters, 2-beat packets: no interleaving, order 0,1,2,3
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      npkt[i] = 1; nbeats[i] = 2;
      exp_q.push_back(DWIDTH'(i << 8));
      exp_q.push_back(DWIDTH'((i << 8) | 1));
    end
    run_to_idle(50, "s2");
    drain("s2_order");

    // requesters 1 and 3, 1-beat packets: alternate grants, write every other cycle
    do_reset();
    npkt[1] = 4; npkt[3] = 4;
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back(DWIDTH'(32'h100 | (p << 4)));
      exp_q.push_back(DWIDTH'(32'h300 | (p << 4)));
    end
    for (int c = 0; c < 8; c++) begin
      step(1'b0);
      chk($sformatf("s3_write_c%0d", c), {63'd0, s_write}, 64'(c % 2));
      if (c % 2 == 1)
        chk($sformatf("s3_grant_c%0d", c), 64'(s_grant), (c % 4 == 1) ? 64'h2 : 64'h8);
    end
    run_to_idle(40, "s3");
    drain("s3_order");

    // requester 2 streams 20 beats into a 16-deep FIFO with no pops, then 4 pops
    do_reset();
    npkt[2] = 1; nbeats[2] = 20;
    for (int b = 0; b < 20; b++) exp_q.push_back(DWIDTH'(32'h200 + b));
    for (int c = 0; c < 40; c++) step(1'b0);
    chk("s4_fill_writes", 64'(n_writes), 64'd16);
    chk("s4_ready_while_full", 64'(rdy_full_cnt), 64'd0);
    chk("s4_fill_grant", 64'({s_busy, s_grant}), 64'h14);
    for (int c = 0; c < 4; c++) step(1'b1);
    run_to_idle(40, "s4");
    chk("s4_total_writes", 64'(n_writes), 64'd20);
    drain("s4_order");

    // owner 1 drops valid for 2 cycles while requester 3 waits
    do_reset();
    npkt[1] = 1; nbeats[1] = 3;
    npkt[3] = 1; nbeats[3] = 2;
    exp_q.push_back(32'h100); exp_q.push_back(32'h101); exp_q.push_back(32'h102);
    exp_q.push_back(32'h300); exp_q.push_back(32'h301);
    step(1'b0);
    step(1'b0);
    chk("s5_first_beat", 64'({s_grant, s_write}), 64'({4'b0010, 1'b1}));
    hold[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step(1'b0);
      chk($sformatf("s5_gap_c%0d", c), 64'({s_grant, s_write}), 64'({4'b0010, 1'b0}));
    end
    hold[1] = 1'b0;
    run_to_idle(30, "s5");
    drain("s5_order");

    // reset mid-packet of requester 2, then requesters 0 and 2 compete
    do_reset();
    npkt[2] = 1; nbeats[2] = 3;
    exp_q.push_back(32'h200); exp_q.push_back(32'h000); exp_q.push_back(32'h210);
    step(1'b0);
    step(1'b0);
    rst = 1'b1;
    hold[2] = 1'b1;
    step(1'b0);
    rst = 1'b0;
    clear_prod();
    npkt[0] = 1;
    pkt[2] = 1; npkt[2] = 2;
    step(1'b0);
    chk("s6_after_rst", 64'({s_grant, s_busy, s_write}), 64'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("s6_cnt_cleared", 64'(grant_cnt), 64'd0);
`endif
    step(1'b0);
    chk("s6_req0_first", 64'({s_grant, s_write, s_din}), 64'({4'b0001, 1'b1, 32'h000}));
    run_to_idle(30, "s6");
    drain("s6_order");
`ifdef FIFO_WR_ARB_STATS_EN
    chk("s6_cnt_final", 64'(grant_cnt), 64'h0000_0001_0000_0001);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
